// File: rtl/axis_upsizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsizer_pkg
//  Purpose  : Shared defaults and parameter-legality helpers for the
//             AXI-Stream width upsizer.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axis_upsizer_pkg;

  localparam int DEFAULT_S_DATA_WIDTH = 8;
  localparam int DEFAULT_RATIO        = 4;
  localparam int MIN_RATIO            = 2;
  localparam int MAX_RATIO            = 16;

  // A ratio is usable only if it is a power of two inside [MIN_RATIO, MAX_RATIO].
  function automatic bit ratio_is_legal(input int ratio);
    return (ratio >= MIN_RATIO) && (ratio <= MAX_RATIO) &&
           ((ratio & (ratio - 1)) == 0);
  endfunction

endpackage : axis_upsizer_pkg
`default_nettype wire

// File: rtl/axis_upsizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsizer_if
//  Purpose  : AXI-Stream bundle used on both sides of the upsizer.
//  Signals  : data  [DATA_WIDTH] payload
//             keep  [KEEP_WIDTH] per-lane valid flags (master side only)
//             valid              beat/word valid
//             last               final beat/word of a packet
//             ready              sink accepts
//  Modports : master - drives data/keep/valid/last, samples ready
//             slave  - samples data/valid/last, drives ready (no keep)
//  Revision : 1.0  initial release
// ============================================================================
interface axis_upsizer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1
) ();

  logic [DATA_WIDTH-1:0] data;
  logic [KEEP_WIDTH-1:0] keep;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (
    output data,
    output keep,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );

endinterface : axis_upsizer_if
`default_nettype wire

// File: rtl/axis_upsizer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_upsizer
//  Purpose  : Packs RATIO narrow AXI-Stream beats into one wide word,
//             little-endian, with per-lane keep and packet-count tracking.
//  Ports    : aclk       in   clock, rising edge
//             areset     in   synchronous active-high reset
//             s_axis     slave  narrow beat stream (S_DATA_WIDTH)
//             m_axis     master wide word stream (M_DATA_WIDTH, keep RATIO)
//             pkt_count  out  16-bit wrapping count of packets sent
//  Revision : 1.0  initial release
// ============================================================================
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int S_DATA_WIDTH = DEFAULT_S_DATA_WIDTH,
  parameter int RATIO        = DEFAULT_RATIO,
  parameter int M_DATA_WIDTH = S_DATA_WIDTH * RATIO
) (
  input  wire                  aclk,
  input  wire                  areset,
  axis_upsizer_if.slave        s_axis,
  axis_upsizer_if.master       m_axis,
  output logic [15:0]          pkt_count
);

  localparam int                 LANE_W    = $clog2(RATIO);
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(RATIO - 1);
  localparam bit                 PARAMS_OK = ratio_is_legal(RATIO) &&
                                             (M_DATA_WIDTH == S_DATA_WIDTH * RATIO);

  if (!PARAMS_OK) begin : g_param_check
    $error("axis_upsizer: illegal RATIO or M_DATA_WIDTH");
  end

  // Partial word being assembled.
  logic [LANE_W-1:0]       lane_q,     lane_d;
  logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [RATIO-1:0]        acc_keep_q, acc_keep_d;

  // Output word register.
  logic [M_DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [RATIO-1:0]        out_keep_q,  out_keep_d;
  logic                    out_last_q,  out_last_d;
  logic                    out_valid_q, out_valid_d;

  logic [15:0]             pkt_count_q, pkt_count_d;

  logic                    s_ready;
  logic                    beat_accept;
  logic                    beat_completes;
  logic                    word_taken;
  logic [M_DATA_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]        merged_keep;

  // Accept whenever the output register is empty or is being drained this
  // cycle; this gives one beat per cycle with no bubble.
  assign s_ready        = !out_valid_q || m_axis.ready;
  assign beat_accept    = s_axis.valid && s_ready;
  assign beat_completes = beat_accept && ((lane_q == LAST_LANE) || s_axis.last);
  assign word_taken     = out_valid_q && m_axis.ready;

  // Accumulator with the incoming beat dropped into its lane.
  always_comb begin
    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_q == LANE_W'(k)) begin
        merged_data[k*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis.data;
        merged_keep[k]                              = 1'b1;
      end
    end
  end

  always_comb begin
    lane_d      = lane_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    pkt_count_d = pkt_count_q;

    if (word_taken) begin
      out_valid_d = 1'b0;
      if (out_last_q) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end

    if (beat_accept) begin
      if (beat_completes) begin
        // A completing beat may coincide with the drain above; the reload
        // overrides the clear so the next word follows without a gap.
        out_data_d  = merged_data;
        out_keep_d  = merged_keep;
        out_last_d  = s_axis.last;
        out_valid_d = 1'b1;
        // Clearing data as well as keep makes the unused upper lanes of a
        // short packet read as zero.
        acc_data_d  = '0;
        acc_keep_d  = '0;
        lane_d      = '0;
      end else begin
        acc_data_d  = merged_data;
        acc_keep_d  = merged_keep;
        lane_d      = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      lane_q      <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      lane_q      <= lane_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign s_axis.ready = s_ready;
  assign m_axis.data  = out_data_q;
  assign m_axis.keep  = out_keep_q;
  assign m_axis.last  = out_last_q;
  assign m_axis.valid = out_valid_q;
  assign pkt_count    = pkt_count_q;

endmodule : axis_upsizer
`default_nettype wire

// File: tb/tb_axis_upsizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_upsizer
//  Purpose  : Self-checking bench for axis_upsizer (8-bit beats, ratio 4).
//             Expected words come from a queue-based packet model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_upsizer;

  localparam int SW = 8;
  localparam int R  = 4;
  localparam int MW = SW * R;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] pkt_count;

  always #5 aclk = ~aclk;

  axis_upsizer_if #(.DATA_WIDTH(SW), .KEEP_WIDTH(1)) s_if ();
  axis_upsizer_if #(.DATA_WIDTH(MW), .KEEP_WIDTH(R)) m_if ();

  axis_upsizer #(
    .S_DATA_WIDTH(SW),
    .RATIO       (R),
    .M_DATA_WIDTH(MW)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_axis   (s_if.slave),
    .m_axis   (m_if.master),
    .pkt_count(pkt_count)
  );

  typedef struct {
    logic [MW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  word_t       exp_q[$];   // words the DUT must present, in order
  logic [7:0]  cur[$];     // beats of the word being assembled
  logic [15:0] exp_pkts;
  int          checks;
  int          errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    cur.delete();
    exp_pkts = '0;
  endfunction

  // One clock cycle: drive at the falling edge, check, then model the edge.
  task automatic cycle(input bit sv, input logic [7:0] sd, input bit sl,
                       input bit mr, output bit acc);
    word_t w;
    bit    rdy;
    @(negedge aclk);
    s_if.valid  = sv;
    s_if.data   = sd;
    s_if.last   = sl;
    m_if.ready  = mr;
    #1;
    rdy = (exp_q.size() == 0) || mr;
    check_val("m_valid",   64'(m_if.valid), 64'(exp_q.size() != 0));
    check_val("s_ready",   64'(s_if.ready), 64'(rdy));
    check_val("pkt_count", 64'(pkt_count),  64'(exp_pkts));
    if (exp_q.size() != 0 && mr) begin
      w = exp_q.pop_front();
      check_val("m_data", 64'(m_if.data), 64'(w.data));
      check_val("m_keep", 64'(m_if.keep), 64'(w.keep));
      check_val("m_last", 64'(m_if.last), 64'(w.last));
      if (w.last) exp_pkts = exp_pkts + 16'd1;
    end
    acc = sv && rdy;
    if (acc) begin
      cur.push_back(sd);
      if (cur.size() == R || sl) begin
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < cur.size(); i++) begin
          w.data = w.data | (MW'(cur[i]) << (SW * i));
          w.keep[i] = 1'b1;
        end
        w.last = sl;
        exp_q.push_back(w);
        cur.delete();
      end
    end
    @(posedge aclk);
  endtask

  task automatic send_beat(input logic [7:0] d, input bit l, input bit mr);
    bit acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) cycle(1'b1, d, l, mr, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=0 exp=1");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset     = 1'b1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    @(posedge aclk);
    #1;
    check_val("rst_valid", 64'(m_if.valid), 64'd0);
    check_val("rst_data",  64'(m_if.data),  64'd0);
    check_val("rst_keep",  64'(m_if.keep),  64'd0);
    check_val("rst_last",  64'(m_if.last),  64'd0);
    check_val("rst_pkts",  64'(pkt_count),  64'd0);
    check_val("rst_ready", 64'(s_if.ready), 64'd1);
    model_reset();
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    checks     = 0;
    errors     = 0;
    areset     = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    s_if.keep  = '1;
    m_if.ready = 1'b0;
    model_reset();
    do_reset();

    // Full word, single packet.
    send_beat(8'h11, 1'b0, 1'b1);
    send_beat(8'h22, 1'b0, 1'b1);
    send_beat(8'h33, 1'b0, 1'b1);
    send_beat(8'h44, 1'b1, 1'b1);
    idle(2);
    check_val("pkt_after_full", 64'(pkt_count), 64'd1);

    // Short packet: upper lanes zero, keep 0011.
    send_beat(8'hAA, 1'b0, 1'b1);
    send_beat(8'hBB, 1'b1, 1'b1);
    #1;
    check_val("short_data", 64'(m_if.data), 64'h0000BBAA);
    check_val("short_keep", 64'(m_if.keep), 64'h3);
    idle(2);

    // One-beat packet.
    send_beat(8'h5C, 1'b1, 1'b1);
    #1;
    check_val("one_keep", 64'(m_if.keep), 64'h1);
    idle(2);

    // Backpressure: first word must hold while stalled.
    for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h05, 1'b0, 1'b0, acc);
      #1;
      check_val("stall_data", 64'(m_if.data), 64'h04030201);
    end
    for (int i = 5; i <= 8; i++) send_beat(8'(i), i == 8, 1'b1);
    idle(2);

    // Back-to-back packets at full rate.
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < R; i++)
        send_beat(8'($urandom), i == R - 1, 1'b1);
    idle(2);

    // Reset mid-packet and with a word pending discards everything.
    send_beat(8'hE1, 1'b0, 1'b1);
    send_beat(8'hE2, 1'b0, 1'b1);
    do_reset();
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4, 1'b1);
    #1;
    check_val("post_rst_data", 64'(m_if.data), 64'h04030201);
    check_val("post_rst_keep", 64'(m_if.keep), 64'hF);
    idle(2);
    for (int i = 0; i < R; i++) send_beat(8'h70 + 8'(i), 1'b0, 1'b1);
    do_reset();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 6, acc);
    idle(3);

    // Packet counter wrap.
    do_reset();
    for (int i = 0; i < 65535; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b1, acc);
    idle(2);
    check_val("pkt_ffff", 64'(pkt_count), 64'hFFFF);
    send_beat(8'h99, 1'b1, 1'b1);
    idle(2);
    check_val("pkt_wrap", 64'(pkt_count), 64'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axis_upsizer
`default_nettype wire
